// File: rtl/pulse_envelope_player.sv
// pulse_envelope_player
// Plays one scheduled pulse command at a time. Each command reads cmd_len
// samples from a synchronous envelope RAM, starting at cmd_env_base. Every
// sample is scaled by a signed Q1.(AMP_W-1) amplitude. The result is streamed
// out as a gapless sample stream with no backpressure.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high in IDLE and in the PLAY cycle that issues the final address.
// It is forced low while flush is high. cmd_* are sampled only on a transfer.
// A transfer with cmd_len == 0 is consumed and produces nothing. The sample
// side has no ready: smp_valid marks each output cycle.
//
// Timing, with the accept cycle numbered 0:
//   cycle 1    : env_rd_en with address base+0
//   cycle 2    : env_rd_data returns
//   cycle 3    : smp_valid with sample 0
//   cycle 3+i  : sample i
// The amplitude travels down the pipeline with each read. Back-to-back
// commands that use different amplitudes therefore scale correctly.
module pulse_envelope_player #(
  parameter int SAMPLE_W = 16,
  parameter int AMP_W    = 16,
  parameter int ENV_AW   = 10,
  parameter int LEN_W    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ENV_AW-1:0]   cmd_env_base,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [AMP_W-1:0]    cmd_amp,
  input  logic                flush,
  output logic                env_rd_en,
  output logic [ENV_AW-1:0]   env_rd_addr,
  input  logic [SAMPLE_W-1:0] env_rd_data,
  output logic                smp_valid,
  output logic [SAMPLE_W-1:0] smp_data,
  output logic                smp_last,
  output logic                busy,
  output logic                state_dbg
);

  localparam int PW = SAMPLE_W + AMP_W;

  // Rounding constant: one half LSB of the result, i.e. 2^(AMP_W-2).
  localparam logic signed [PW-1:0] RND_HALF =
    {{(PW-AMP_W+1){1'b0}}, 1'b1, {(AMP_W-2){1'b0}}};
  // Representable output range, sign-extended to the product width.
  localparam logic signed [PW-1:0] SAT_MAX_W =
    {{(PW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN_W =
    {{(PW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ENV_AW-1:0] addr_r, addr_nxt;   // address issued this PLAY cycle
  logic [LEN_W-1:0]  cnt_r, cnt_nxt;     // reads remaining after this one
  logic [AMP_W-1:0]  amp_r, amp_nxt;     // amplitude of the pulse being read

  logic last_addr;
  logic accept;

  // Stage 1 tracks the read that is in flight. Its data arrives on env_rd_data.
  logic             s1_valid;
  logic             s1_last;
  logic [AMP_W-1:0] s1_amp;

  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  prod_rnd;
  logic signed [PW-1:0]  shifted;
  logic [SAMPLE_W-1:0]   sat_val;

  // Handshake and read-port decode.
  always_comb begin
    last_addr   = (state == ST_PLAY) && (cnt_r == '0);
    cmd_ready   = !flush && ((state == ST_IDLE) || last_addr);
    accept      = cmd_valid && cmd_ready && (cmd_len != '0);
    env_rd_en   = (state == ST_PLAY);
    env_rd_addr = (state == ST_PLAY) ? addr_r : '0;
    busy        = (state == ST_PLAY) || s1_valid || smp_valid;
    state_dbg   = state;
  end

  // Next state. flush wins over any command. A command accepted in the final
  // address cycle reloads the counters so that its address 0 follows directly.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_r;
    cnt_nxt   = cnt_r;
    amp_nxt   = amp_r;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else if (accept) begin
      state_nxt = ST_PLAY;
      addr_nxt  = cmd_env_base;
      cnt_nxt   = cmd_len - LEN_W'(1);
      amp_nxt   = cmd_amp;
    end else if (state == ST_PLAY) begin
      if (last_addr) begin
        state_nxt = ST_IDLE;
      end else begin
        addr_nxt = addr_r + ENV_AW'(1);   // wraps modulo 2^ENV_AW
        cnt_nxt  = cnt_r - LEN_W'(1);
      end
    end
  end

  // FSM and read-counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      addr_r <= '0;
      cnt_r  <= '0;
      amp_r  <= '0;
    end else begin
      state  <= state_nxt;
      addr_r <= addr_nxt;
      cnt_r  <= cnt_nxt;
      amp_r  <= amp_nxt;
    end
  end

  // Scale: full-width product, round half up, arithmetic shift, saturate.
  always_comb begin
    prod     = $signed(env_rd_data) * $signed(s1_amp);
    prod_rnd = prod + RND_HALF;
    shifted  = prod_rnd >>> (AMP_W - 1);
    if (shifted > SAT_MAX_W) begin
      sat_val = SAT_MAX;
    end else if (shifted < SAT_MIN_W) begin
      sat_val = SAT_MIN;
    end else begin
      sat_val = shifted[SAMPLE_W-1:0];
    end
  end

  // Sample pipeline. flush drops the valid bits but leaves the data registers
  // alone. smp_data holds its value between valid samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_amp    <= '0;
      smp_valid <= 1'b0;
      smp_data  <= '0;
      smp_last  <= 1'b0;
    end else begin
      s1_amp  <= amp_r;
      s1_last <= last_addr;
      if (flush) begin
        s1_valid  <= 1'b0;
        smp_valid <= 1'b0;
        smp_last  <= 1'b0;
      end else begin
        s1_valid  <= env_rd_en;
        smp_valid <= s1_valid;
        smp_last  <= s1_valid && s1_last;
        if (s1_valid) begin
          smp_data <= sat_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_envelope_player.sv
// Bench for pulse_envelope_player. It is driven cycle by cycle from a
// table-driven vector list and from hand sequences for flush and mid-pulse
// reset. The envelope RAM is a one-cycle-latency behavioural array.
module tb_pulse_envelope_player;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_env_base;
  logic [9:0]  cmd_len;
  logic [15:0] cmd_amp;
  logic        flush;
  logic        env_rd_en;
  logic [9:0]  env_rd_addr;
  logic [15:0] env_rd_data;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        smp_last;
  logic        busy;
  logic        state_dbg;

  int n_checks;
  int n_fail;

  logic [15:0] ram [0:1023];

  typedef struct {
    logic        cv;
    logic [9:0]  base;
    logic [9:0]  len;
    logic [15:0] amp;
    logic        fl;
    logic        rdy;
    logic        rd;
    logic [9:0]  addr;
    logic        sv;
    logic [15:0] sd;
    logic        sl;
    logic        busy;
  } vec_t;

  vec_t vecs [31];

  pulse_envelope_player #(
    .SAMPLE_W(16), .AMP_W(16), .ENV_AW(10), .LEN_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_env_base(cmd_env_base), .cmd_len(cmd_len), .cmd_amp(cmd_amp),
    .flush(flush),
    .env_rd_en(env_rd_en), .env_rd_addr(env_rd_addr), .env_rd_data(env_rd_data),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_last(smp_last),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Envelope RAM: data is valid one cycle after env_rd_en
  always @(posedge clk) begin
    if (env_rd_en) env_rd_data <= ram[env_rd_addr];
  end

  function automatic vec_t mk(input int cv, input int base, input int len,
                              input int amp, input int fl, input int rdy,
                              input int rd, input int addr, input int sv,
                              input int sd, input int sl, input int bsy);
    vec_t v;
    v.cv = 1'(cv);   v.base = 10'(base); v.len = 10'(len); v.amp = 16'(amp);
    v.fl = 1'(fl);   v.rdy = 1'(rdy);    v.rd = 1'(rd);    v.addr = 10'(addr);
    v.sv = 1'(sv);   v.sd = 16'(sd);     v.sl = 1'(sl);    v.busy = 1'(bsy);
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Driver: inputs change on the falling edge; outputs are checked 1 ns later.
  task automatic drive(input int cv, input int base, input int len, input int amp, input int fl);
    @(negedge clk);
    cmd_valid    = 1'(cv);
    cmd_env_base = 10'(base);
    cmd_len      = 10'(len);
    cmd_amp      = 16'(amp);
    flush        = 1'(fl);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " cmd_ready"}, 16'(cmd_ready), 16'd1);
    chk({tag, " env_rd_en"}, 16'(env_rd_en), 16'd0);
    chk({tag, " env_rd_addr"}, 16'(env_rd_addr), 16'd0);
    chk({tag, " smp_valid"}, 16'(smp_valid), 16'd0);
    chk({tag, " smp_data"}, smp_data, 16'd0);
    chk({tag, " smp_last"}, 16'(smp_last), 16'd0);
    chk({tag, " busy"}, 16'(busy), 16'd0);
    chk({tag, " state"}, 16'(state_dbg), 16'd0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      drive(int'(vecs[k].cv), int'(vecs[k].base), int'(vecs[k].len),
            int'(vecs[k].amp), int'(vecs[k].fl));
      chk($sformatf("row%0d cmd_ready", k), 16'(cmd_ready), 16'(vecs[k].rdy));
      chk($sformatf("row%0d env_rd_en", k), 16'(env_rd_en), 16'(vecs[k].rd));
      if (vecs[k].rd)
        chk($sformatf("row%0d env_rd_addr", k), 16'(env_rd_addr), 16'(vecs[k].addr));
      chk($sformatf("row%0d smp_valid", k), 16'(smp_valid), 16'(vecs[k].sv));
      if (vecs[k].sv)
        chk($sformatf("row%0d smp_data", k), smp_data, vecs[k].sd);
      chk($sformatf("row%0d smp_last", k), 16'(smp_last), 16'(vecs[k].sl));
      chk($sformatf("row%0d busy", k), 16'(busy), 16'(vecs[k].busy));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int a = 0; a < 1024; a++) ram[a] = 16'd0;
    ram[5]  = 16'(1000);   ram[6]  = 16'(-1000);
    ram[7]  = 16'(32767);  ram[8]  = 16'(-32768);
    ram[20] = 16'(2000);   ram[21] = 16'(-3000);
    ram[40] = 16'(4000);   ram[41] = 16'(-4000);  ram[42] = 16'(10);
    ram[1022] = 16'(-32768); ram[1023] = 16'(100);
    ram[0]  = 16'(32767);  ram[1] = 16'(0);
    ram[50] = 16'(-7);
    ram[100] = 16'(200);

    //                cv base len  amp    fl  rdy rd addr  sv sd      sl busy
    // Scenario 1: base 5, len 4, amp 0.5
    vecs[0]  = mk(1, 5,    4, 'h4000, 0,  1, 0, 0,    0, 0,      0, 0);
    vecs[1]  = mk(0, 0,    0, 0,      0,  0, 1, 5,    0, 0,      0, 1);
    vecs[2]  = mk(0, 0,    0, 0,      0,  0, 1, 6,    0, 0,      0, 1);
    vecs[3]  = mk(0, 0,    0, 0,      0,  0, 1, 7,    1, 500,    0, 1);
    vecs[4]  = mk(0, 0,    0, 0,      0,  1, 1, 8,    1, -500,   0, 1);
    vecs[5]  = mk(0, 0,    0, 0,      0,  1, 0, 0,    1, 16384,  0, 1);
    vecs[6]  = mk(0, 0,    0, 0,      0,  1, 0, 0,    1, -16384, 1, 1);
    vecs[7]  = mk(0, 0,    0, 0,      0,  1, 0, 0,    0, 0,      0, 0);
    // Scenario 2: A (len 2, amp 0x7FFF) then B (len 3, amp 0.25), valid held
    vecs[8]  = mk(1, 20,   2, 'h7FFF, 0,  1, 0, 0,    0, 0,      0, 0);
    vecs[9]  = mk(1, 40,   3, 'h2000, 0,  0, 1, 20,   0, 0,      0, 1);
    vecs[10] = mk(1, 40,   3, 'h2000, 0,  1, 1, 21,   0, 0,      0, 1);
    vecs[11] = mk(0, 0,    0, 0,      0,  0, 1, 40,   1, 2000,   0, 1);
    vecs[12] = mk(0, 0,    0, 0,      0,  0, 1, 41,   1, -3000,  1, 1);
    vecs[13] = mk(0, 0,    0, 0,      0,  1, 1, 42,   1, 1000,   0, 1);
    vecs[14] = mk(0, 0,    0, 0,      0,  1, 0, 0,    1, -1000,  0, 1);
    vecs[15] = mk(0, 0,    0, 0,      0,  1, 0, 0,    1, 3,      1, 1);
    vecs[16] = mk(0, 0,    0, 0,      0,  1, 0, 0,    0, 0,      0, 0);
    // Scenario 3: address wrap and saturation, amp -1.0
    vecs[17] = mk(1, 1022, 4, 'h8000, 0,  1, 0, 0,    0, 0,      0, 0);
    vecs[18] = mk(0, 0,    0, 0,      0,  0, 1, 1022, 0, 0,      0, 1);
    vecs[19] = mk(0, 0,    0, 0,      0,  0, 1, 1023, 0, 0,      0, 1);
    vecs[20] = mk(0, 0,    0, 0,      0,  0, 1, 0,    1, 32767,  0, 1);
    vecs[21] = mk(0, 0,    0, 0,      0,  1, 1, 1,    1, -100,   0, 1);
    vecs[22] = mk(0, 0,    0, 0,      0,  1, 0, 0,    1, -32767, 0, 1);
    vecs[23] = mk(0, 0,    0, 0,      0,  1, 0, 0,    1, 0,      1, 1);
    vecs[24] = mk(0, 0,    0, 0,      0,  1, 0, 0,    0, 0,      0, 0);
    // Scenario 4: len 0 no-op, then a 1-sample pulse
    vecs[25] = mk(1, 7,    0, 1,      0,  1, 0, 0,    0, 0,      0, 0);
    vecs[26] = mk(1, 50,   1, 'h4000, 0,  1, 0, 0,    0, 0,      0, 0);
    vecs[27] = mk(0, 0,    0, 0,      0,  1, 1, 50,   0, 0,      0, 1);
    vecs[28] = mk(0, 0,    0, 0,      0,  1, 0, 0,    0, 0,      0, 1);
    vecs[29] = mk(0, 0,    0, 0,      0,  1, 0, 0,    1, -3,     1, 1);
    vecs[30] = mk(0, 0,    0, 0,      0,  1, 0, 0,    0, 0,      0, 0);

    // Reset
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_env_base = '0; cmd_len = '0; cmd_amp = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_values("reset");

    run_rows(0, 30);

    // Mid-pulse reset: drop rst_n for one cycle while sample 0 is on the output
    drive(1, 5, 4, 'h4000, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    chk("pre-reset smp_valid", 16'(smp_valid), 16'd1);
    chk("pre-reset smp_data", smp_data, 16'd500);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    check_reset_values("midreset");
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 0, 0, 0);
      chk($sformatf("post-reset smp_valid c%0d", c), 16'(smp_valid), 16'd0);
      chk($sformatf("post-reset env_rd_en c%0d", c), 16'(env_rd_en), 16'd0);
    end
    run_rows(0, 7);

    // Flush in cycle 3 of a len 8 pulse with a competing command
    drive(1, 100, 8, 'h4000, 0);
    chk("flush c0 cmd_ready", 16'(cmd_ready), 16'd1);
    drive(0, 0, 0, 0, 0);
    chk("flush c1 state", 16'(state_dbg), 16'd1);
    drive(0, 0, 0, 0, 0);
    drive(1, 5, 4, 'h4000, 1);
    chk("flush c3 cmd_ready", 16'(cmd_ready), 16'd0);
    chk("flush c3 smp_valid", 16'(smp_valid), 16'd1);
    chk("flush c3 smp_data", smp_data, 16'd100);
    drive(0, 0, 0, 0, 0);
    chk("flush c4 smp_valid", 16'(smp_valid), 16'd0);
    chk("flush c4 smp_last", 16'(smp_last), 16'd0);
    chk("flush c4 busy", 16'(busy), 16'd0);
    chk("flush c4 cmd_ready", 16'(cmd_ready), 16'd1);
    chk("flush c4 state", 16'(state_dbg), 16'd0);
    chk("flush c4 env_rd_en", 16'(env_rd_en), 16'd0);
    chk("flush c4 smp_data held", smp_data, 16'd100);
    for (int c = 5; c < 9; c++) begin
      drive(0, 0, 0, 0, 0);
      chk($sformatf("flush c%0d smp_valid", c), 16'(smp_valid), 16'd0);
      chk($sformatf("flush c%0d env_rd_en", c), 16'(env_rd_en), 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
